// File: rtl/fetch_pkg.sv
// Shared fetch-stage encodings: PC source selects and controller FSM states.
// Reused by fetchCycle and decode control so the PC mux encoding has one definition.
package fetch_pkg;

  typedef logic [1:0] pc_src_t;

  localparam pc_src_t PCSRC_NEXT   = 2'b00;
  localparam pc_src_t PCSRC_BRANCH = 2'b01;
  localparam pc_src_t PCSRC_JUMP   = 2'b10;
  localparam pc_src_t PCSRC_HOLD   = 2'b11;

  typedef enum logic [2:0] {
    ST_RESET_HOLD = 3'd0,
    ST_RUN        = 3'd1,
    ST_WAIT_MEM   = 3'd2,
    ST_HALT       = 3'd3
  } state_t;

  localparam int HOLD_CNT_W = 4;

endpackage

// File: rtl/fetch_controller_if.sv
// Request/control bundle between hazard logic, the fetch controller and the fetch datapath.
// The slave side is the controller; the master side drives requests and consumes the selects.
interface fetch_controller_if #(
  parameter int CNT_W = 16
);
  import fetch_pkg::*;

  logic             stallReq;
  logic             branchTaken;
  logic             jumpReq;
  logic             haltReq;
  logic             resume;
  logic             imemReady;
  pc_src_t          PC_Src;
  logic             pcWrite;
  logic             ifIdWrite;
  logic             ifIdFlush;
  logic             fetchValid;
  logic [2:0]       state;
  logic [CNT_W-1:0] redirectCount;

  modport slave (
    input  stallReq, branchTaken, jumpReq, haltReq, resume, imemReady,
    output PC_Src, pcWrite, ifIdWrite, ifIdFlush, fetchValid, state, redirectCount
  );

  modport master (
    output stallReq, branchTaken, jumpReq, haltReq, resume, imemReady,
    input  PC_Src, pcWrite, ifIdWrite, ifIdFlush, fetchValid, state, redirectCount
  );

endinterface

// File: rtl/redirect_pending_buf.sv
// One-entry store for a redirect seen while instruction memory stalls; a branch
// replaces a queued jump, a jump never displaces a queued branch. Capture/clear visible next cycle.
module redirect_pending_buf
  import fetch_pkg::*;
(
  input  logic    clk,
  input  logic    rst,
  input  logic    cap_branch,
  input  logic    cap_jump,
  input  logic    clear,
  output logic    pend_vld,
  output pc_src_t pend_sel
);

  logic    pend_vld_q, pend_vld_d;
  pc_src_t pend_sel_q, pend_sel_d;

  always_comb begin
    pend_vld_d = pend_vld_q;
    pend_sel_d = pend_sel_q;
    if (clear) begin
      pend_vld_d = 1'b0;
      pend_sel_d = PCSRC_NEXT;
    end else if (cap_branch) begin
      pend_vld_d = 1'b1;
      pend_sel_d = PCSRC_BRANCH;
    end else if (cap_jump && !(pend_vld_q && pend_sel_q == PCSRC_BRANCH)) begin
      pend_vld_d = 1'b1;
      pend_sel_d = PCSRC_JUMP;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend_vld_q <= 1'b0;
      pend_sel_q <= PCSRC_NEXT;
    end else begin
      pend_vld_q <= pend_vld_d;
      pend_sel_q <= pend_sel_d;
    end
  end

  assign pend_vld = pend_vld_q;
  assign pend_sel = pend_sel_q;

endmodule

// File: rtl/fetch_controller.sv
// Fetch-stage sequencer: selects PC source and IF/ID load/flush from redirect, stall, halt and imem-wait.
// Mealy outputs take effect on the next edge; memory not ready holds the PC and buffers one redirect.
module fetch_controller
  import fetch_pkg::*;
#(
  parameter int RESET_HOLD_CYCLES = 2,
  parameter int CNT_W             = 16
) (
  input  logic               clk,
  input  logic               rst,
  fetch_controller_if.slave  bus
);

  state_t                state_q, state_d;
  logic [HOLD_CNT_W-1:0] hold_cnt_q, hold_cnt_d;
  logic [CNT_W-1:0]      redir_cnt_q, redir_cnt_d;

  pc_src_t pc_src;
  logic    pc_write, if_id_write, if_id_flush;
  logic    redirect;
  logic    cap_branch, cap_jump, pend_clr;
  logic    pend_vld;
  pc_src_t pend_sel;

  redirect_pending_buf u_pend (
    .clk        (clk),
    .rst        (rst),
    .cap_branch (cap_branch),
    .cap_jump   (cap_jump),
    .clear      (pend_clr),
    .pend_vld   (pend_vld),
    .pend_sel   (pend_sel)
  );

  always_comb begin
    state_d     = state_q;
    hold_cnt_d  = '0;
    pc_src      = PCSRC_HOLD;
    pc_write    = 1'b0;
    if_id_write = 1'b0;
    if_id_flush = 1'b0;
    redirect    = 1'b0;
    cap_branch  = 1'b0;
    cap_jump    = 1'b0;
    pend_clr    = 1'b0;

    case (state_q)
      ST_RESET_HOLD: begin
        if_id_flush = 1'b1;
        hold_cnt_d  = hold_cnt_q + 4'd1;
        if (hold_cnt_q == HOLD_CNT_W'(RESET_HOLD_CYCLES - 1)) state_d = ST_RUN;
      end
      ST_RUN: begin
        // Redirects need no memory data since the slot is flushed, so they bypass the imem check.
        if (bus.branchTaken) begin
          pc_src   = PCSRC_BRANCH;
          redirect = 1'b1;
        end else if (bus.jumpReq) begin
          pc_src   = PCSRC_JUMP;
          redirect = 1'b1;
        end else if (bus.stallReq) begin
          pc_src = PCSRC_HOLD;
        end else if (bus.haltReq) begin
          state_d = ST_HALT;
        end else if (!bus.imemReady) begin
          state_d = ST_WAIT_MEM;
        end else begin
          pc_src      = PCSRC_NEXT;
          pc_write    = 1'b1;
          if_id_write = 1'b1;
        end
      end
      ST_WAIT_MEM: begin
        if (bus.imemReady) begin
          state_d  = ST_RUN;
          pend_clr = 1'b1;
          if (bus.branchTaken) begin
            pc_src   = PCSRC_BRANCH;
            redirect = 1'b1;
          end else if (bus.jumpReq) begin
            pc_src   = PCSRC_JUMP;
            redirect = 1'b1;
          end else if (pend_vld) begin
            pc_src   = pend_sel;
            redirect = 1'b1;
          end else begin
            pc_src      = PCSRC_NEXT;
            pc_write    = 1'b1;
            if_id_write = 1'b1;
          end
        end else begin
          cap_branch = bus.branchTaken;
          cap_jump   = bus.jumpReq;
        end
      end
      ST_HALT: begin
        if (bus.resume) state_d = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase

    if (redirect) begin
      pc_write    = 1'b1;
      if_id_write = 1'b1;
      if_id_flush = 1'b1;
    end
  end

  always_comb begin
    redir_cnt_d = redir_cnt_q;
    if (redirect && redir_cnt_q != {CNT_W{1'b1}}) redir_cnt_d = redir_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_RESET_HOLD;
      hold_cnt_q  <= '0;
      redir_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      hold_cnt_q  <= hold_cnt_d;
      redir_cnt_q <= redir_cnt_d;
    end
  end

  assign bus.PC_Src        = pc_src;
  assign bus.pcWrite       = pc_write;
  assign bus.ifIdWrite     = if_id_write;
  assign bus.ifIdFlush     = if_id_flush;
  assign bus.fetchValid    = if_id_write & ~if_id_flush;
  assign bus.state         = state_q;
  assign bus.redirectCount = redir_cnt_q;

endmodule

// File: tb/tb_fetch_controller.sv
// Directed bench for fetch_controller; narrow redirect counter so saturation is reachable.
module tb_fetch_controller;
  localparam int TB_CNT_W = 3;

  logic clk;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;

  fetch_controller_if #(.CNT_W(TB_CNT_W)) bus ();

  fetch_controller #(.RESET_HOLD_CYCLES(2), .CNT_W(TB_CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic idle_inputs();
    bus.stallReq = 0; bus.branchTaken = 0; bus.jumpReq = 0;
    bus.haltReq = 0; bus.resume = 0; bus.imemReady = 1;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    #2 rst = 1'b0;
    @(negedge clk); @(negedge clk); #1;
    n_checks++; if (bus.state !== 3'd0) begin n_fail++; $display("FAIL rst_state got=%0d exp=0", bus.state); end
    n_checks++; if (bus.PC_Src !== 2'd3) begin n_fail++; $display("FAIL rst_pcsrc got=%0d exp=3", bus.PC_Src); end
    n_checks++; if (bus.pcWrite !== 1'b0 || bus.ifIdWrite !== 1'b0) begin n_fail++; $display("FAIL rst_write got=%b%b exp=00", bus.pcWrite, bus.ifIdWrite); end
    n_checks++; if (bus.ifIdFlush !== 1'b1 || bus.fetchValid !== 1'b0) begin n_fail++; $display("FAIL rst_flush got=%b%b exp=10", bus.ifIdFlush, bus.fetchValid); end
    n_checks++; if (bus.redirectCount !== 3'd0) begin n_fail++; $display("FAIL rst_count got=%0d exp=0", bus.redirectCount); end
    @(negedge clk); rst = 1'b1; #1;
    n_checks++; if (bus.pcWrite !== 1'b0) begin n_fail++; $display("FAIL rel_c1_pcw got=%b exp=0", bus.pcWrite); end
    @(negedge clk); #1;
    n_checks++; if (bus.pcWrite !== 1'b0 || bus.state !== 3'd0) begin n_fail++; $display("FAIL rel_c2 got pcw=%b st=%0d exp pcw=0 st=0", bus.pcWrite, bus.state); end
    @(negedge clk); #1;
    n_checks++; if (bus.PC_Src !== 2'd0 || bus.pcWrite !== 1'b1 || bus.fetchValid !== 1'b1) begin n_fail++; $display("FAIL rel_c3 got src=%0d pcw=%b fv=%b exp src=0 pcw=1 fv=1", bus.PC_Src, bus.pcWrite, bus.fetchValid); end
    n_checks++; if (bus.redirectCount !== 3'd0) begin n_fail++; $display("FAIL rel_count got=%0d exp=0", bus.redirectCount); end
  endtask

  task automatic test_branch();
    @(negedge clk); bus.branchTaken = 1; #1;
    n_checks++; if (bus.PC_Src !== 2'd1 || bus.pcWrite !== 1'b1) begin n_fail++; $display("FAIL br_sel got src=%0d pcw=%b exp src=1 pcw=1", bus.PC_Src, bus.pcWrite); end
    n_checks++; if (bus.ifIdFlush !== 1'b1 || bus.fetchValid !== 1'b0) begin n_fail++; $display("FAIL br_flush got fl=%b fv=%b exp fl=1 fv=0", bus.ifIdFlush, bus.fetchValid); end
    @(negedge clk); bus.branchTaken = 0; #1;
    n_checks++; if (bus.redirectCount !== 3'd1) begin n_fail++; $display("FAIL br_count got=%0d exp=1", bus.redirectCount); end
    n_checks++; if (bus.PC_Src !== 2'd0 || bus.state !== 3'd1) begin n_fail++; $display("FAIL br_after got src=%0d st=%0d exp src=0 st=1", bus.PC_Src, bus.state); end
  endtask

  task automatic test_stall_vs_branch();
    @(negedge clk); bus.stallReq = 1; #1;
    n_checks++; if (bus.PC_Src !== 2'd3 || bus.pcWrite !== 1'b0 || bus.ifIdWrite !== 1'b0) begin n_fail++; $display("FAIL st_c1 got src=%0d pcw=%b ifw=%b exp 3/0/0", bus.PC_Src, bus.pcWrite, bus.ifIdWrite); end
    n_checks++; if (bus.ifIdFlush !== 1'b0) begin n_fail++; $display("FAIL st_c1_flush got=%b exp=0", bus.ifIdFlush); end
    @(negedge clk); bus.branchTaken = 1; #1;
    n_checks++; if (bus.PC_Src !== 2'd1 || bus.ifIdFlush !== 1'b1) begin n_fail++; $display("FAIL st_c2 got src=%0d fl=%b exp src=1 fl=1", bus.PC_Src, bus.ifIdFlush); end
    @(negedge clk); bus.branchTaken = 0; #1;
    n_checks++; if (bus.PC_Src !== 2'd3 || bus.pcWrite !== 1'b0) begin n_fail++; $display("FAIL st_c3 got src=%0d pcw=%b exp src=3 pcw=0", bus.PC_Src, bus.pcWrite); end
    n_checks++; if (bus.redirectCount !== 3'd2) begin n_fail++; $display("FAIL st_count got=%0d exp=2", bus.redirectCount); end
    @(negedge clk); bus.stallReq = 0; #1;
    n_checks++; if (bus.PC_Src !== 2'd0) begin n_fail++; $display("FAIL st_after got=%0d exp=0", bus.PC_Src); end
  endtask

  task automatic test_mem_wait();
    @(negedge clk); bus.imemReady = 0; #1;
    n_checks++; if (bus.PC_Src !== 2'd3 || bus.pcWrite !== 1'b0 || bus.state !== 3'd1) begin n_fail++; $display("FAIL mw_c1 got src=%0d pcw=%b st=%0d exp 3/0/1", bus.PC_Src, bus.pcWrite, bus.state); end
    @(negedge clk); bus.jumpReq = 1; #1;
    n_checks++; if (bus.state !== 3'd2 || bus.PC_Src !== 2'd3) begin n_fail++; $display("FAIL mw_c2 got st=%0d src=%0d exp st=2 src=3", bus.state, bus.PC_Src); end
    @(negedge clk); bus.jumpReq = 0; bus.branchTaken = 1; #1;
    n_checks++; if (bus.state !== 3'd2 || bus.pcWrite !== 1'b0) begin n_fail++; $display("FAIL mw_c3 got st=%0d pcw=%b exp st=2 pcw=0", bus.state, bus.pcWrite); end
    @(negedge clk); bus.branchTaken = 0; #1;
    n_checks++; if (bus.state !== 3'd2 || bus.ifIdWrite !== 1'b0) begin n_fail++; $display("FAIL mw_c4 got st=%0d ifw=%b exp st=2 ifw=0", bus.state, bus.ifIdWrite); end
    @(negedge clk); bus.imemReady = 1; #1;
    n_checks++; if (bus.PC_Src !== 2'd1 || bus.ifIdFlush !== 1'b1 || bus.pcWrite !== 1'b1) begin n_fail++; $display("FAIL mw_ready got src=%0d fl=%b pcw=%b exp 1/1/1", bus.PC_Src, bus.ifIdFlush, bus.pcWrite); end
    @(negedge clk); #1;
    n_checks++; if (bus.redirectCount !== 3'd3) begin n_fail++; $display("FAIL mw_count got=%0d exp=3", bus.redirectCount); end
    n_checks++; if (bus.state !== 3'd1 || bus.PC_Src !== 2'd0) begin n_fail++; $display("FAIL mw_after got st=%0d src=%0d exp st=1 src=0", bus.state, bus.PC_Src); end
  endtask

  task automatic test_wait_merge();
    // Branch queued first, later jump must not displace it.
    @(negedge clk); bus.imemReady = 0;
    @(negedge clk); bus.branchTaken = 1;
    @(negedge clk); bus.branchTaken = 0; bus.jumpReq = 1;
    @(negedge clk); bus.jumpReq = 0; bus.imemReady = 1; #1;
    n_checks++; if (bus.PC_Src !== 2'd1) begin n_fail++; $display("FAIL mg_keep_branch got=%0d exp=1", bus.PC_Src); end
    // Same-cycle jump on ready overrides a queued branch.
    @(negedge clk); bus.imemReady = 0;
    @(negedge clk); bus.branchTaken = 1;
    @(negedge clk); bus.branchTaken = 0; bus.jumpReq = 1; bus.imemReady = 1; #1;
    n_checks++; if (bus.PC_Src !== 2'd2 || bus.ifIdFlush !== 1'b1) begin n_fail++; $display("FAIL mg_override got src=%0d fl=%b exp src=2 fl=1", bus.PC_Src, bus.ifIdFlush); end
    // Ready with nothing queued advances normally.
    @(negedge clk); bus.jumpReq = 0; bus.imemReady = 0;
    @(negedge clk); bus.stallReq = 1; bus.haltReq = 1;
    @(negedge clk); bus.stallReq = 0; bus.haltReq = 0; bus.imemReady = 1; #1;
    n_checks++; if (bus.PC_Src !== 2'd0 || bus.fetchValid !== 1'b1) begin n_fail++; $display("FAIL mg_empty got src=%0d fv=%b exp src=0 fv=1", bus.PC_Src, bus.fetchValid); end
    n_checks++; if (bus.redirectCount !== 3'd5) begin n_fail++; $display("FAIL mg_count got=%0d exp=5", bus.redirectCount); end
  endtask

  task automatic test_branch_jump();
    @(negedge clk); bus.branchTaken = 1; bus.jumpReq = 1; #1;
    n_checks++; if (bus.PC_Src !== 2'd1) begin n_fail++; $display("FAIL bj_sel got=%0d exp=1", bus.PC_Src); end
    @(negedge clk); bus.branchTaken = 0; bus.jumpReq = 0; #1;
    n_checks++; if (bus.PC_Src !== 2'd0 || bus.redirectCount !== 3'd6) begin n_fail++; $display("FAIL bj_drop got src=%0d cnt=%0d exp src=0 cnt=6", bus.PC_Src, bus.redirectCount); end
  endtask

  task automatic test_halt();
    @(negedge clk); bus.haltReq = 1; #1;
    n_checks++; if (bus.PC_Src !== 2'd3 || bus.pcWrite !== 1'b0) begin n_fail++; $display("FAIL h_req got src=%0d pcw=%b exp 3/0", bus.PC_Src, bus.pcWrite); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); bus.haltReq = 0; bus.branchTaken = (i != 1); #1;
      n_checks++; if (bus.state !== 3'd3 || bus.pcWrite !== 1'b0 || bus.ifIdFlush !== 1'b0) begin n_fail++; $display("FAIL h_hold%0d got st=%0d pcw=%b fl=%b exp 3/0/0", i, bus.state, bus.pcWrite, bus.ifIdFlush); end
    end
    @(negedge clk); bus.branchTaken = 0; bus.resume = 1; #1;
    n_checks++; if (bus.state !== 3'd3 || bus.pcWrite !== 1'b0) begin n_fail++; $display("FAIL h_resume got st=%0d pcw=%b exp 3/0", bus.state, bus.pcWrite); end
    @(negedge clk); bus.resume = 0; #1;
    n_checks++; if (bus.state !== 3'd1 || bus.PC_Src !== 2'd0 || bus.pcWrite !== 1'b1) begin n_fail++; $display("FAIL h_run got st=%0d src=%0d pcw=%b exp 1/0/1", bus.state, bus.PC_Src, bus.pcWrite); end
    n_checks++; if (bus.redirectCount !== 3'd6) begin n_fail++; $display("FAIL h_count got=%0d exp=6", bus.redirectCount); end
  endtask

  task automatic test_async_reset();
    @(negedge clk); bus.imemReady = 0;
    @(negedge clk); bus.branchTaken = 1;
    @(negedge clk); bus.branchTaken = 0;
    @(posedge clk); #3 rst = 1'b0; #1;
    n_checks++; if (bus.state !== 3'd0 || bus.PC_Src !== 2'd3 || bus.ifIdFlush !== 1'b1) begin n_fail++; $display("FAIL ar_now got st=%0d src=%0d fl=%b exp 0/3/1", bus.state, bus.PC_Src, bus.ifIdFlush); end
    n_checks++; if (bus.redirectCount !== 3'd0) begin n_fail++; $display("FAIL ar_count got=%0d exp=0", bus.redirectCount); end
    @(negedge clk); rst = 1'b1; bus.imemReady = 1;
    @(negedge clk); @(negedge clk); #1;
    n_checks++; if (bus.PC_Src !== 2'd0 || bus.ifIdFlush !== 1'b0 || bus.redirectCount !== 3'd0) begin n_fail++; $display("FAIL ar_nopend got src=%0d fl=%b cnt=%0d exp 0/0/0", bus.PC_Src, bus.ifIdFlush, bus.redirectCount); end
  endtask

  task automatic test_back_to_back();
    int exp_cnt;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk); bus.branchTaken = 1; #1;
      exp_cnt = (i > 7) ? 7 : i;
      n_checks++; if (bus.PC_Src !== 2'd1 || bus.redirectCount !== 3'(exp_cnt)) begin n_fail++; $display("FAIL b2b%0d got src=%0d cnt=%0d exp src=1 cnt=%0d", i, bus.PC_Src, bus.redirectCount, exp_cnt); end
    end
    @(negedge clk); bus.branchTaken = 0; #1;
    n_checks++; if (bus.redirectCount !== 3'd7) begin n_fail++; $display("FAIL b2b_sat got=%0d exp=7", bus.redirectCount); end
  endtask

  initial begin
    test_reset();
    test_branch();
    test_stall_vs_branch();
    test_mem_wait();
    test_wait_merge();
    test_branch_jump();
    test_halt();
    test_async_reset();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
